// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_ctrl_pkg                                                               |
// | Shared FSM encoding and address/config helpers for the FIR reload sequencer|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RELOAD = 2'd1,
        ST_CONFIG = 2'd2
    } state_t;

    // The config word is the set index with every bit above SEL_WIDTH forced to zero.
    function automatic logic [31:0] cfg_pad(input logic [31:0] sel, input int unsigned sel_width);
        logic [31:0] mask;
        mask = (sel_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sel_width) - 32'd1);
        return sel & mask;
    endfunction

    function automatic int unsigned coeff_addr(input int unsigned sel,
                                               input int unsigned tap,
                                               input int unsigned num_taps);
        return sel * num_taps + tap;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_coeff_loader_if                                                        |
// | Reload and config AXI-Stream channels toward the reloadable FIR            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fir_coeff_loader_if #(
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned CFG_WIDTH   = 8
) ();
    logic                   m_reload_tvalid;
    logic [COEFF_WIDTH-1:0] m_reload_tdata;
    logic                   m_reload_tlast;
    logic                   m_reload_tready;
    logic                   m_config_tvalid;
    logic [CFG_WIDTH-1:0]   m_config_tdata;
    logic                   m_config_tready;

    modport master (
        output m_reload_tvalid, m_reload_tdata, m_reload_tlast,
        input  m_reload_tready,
        output m_config_tvalid, m_config_tdata,
        input  m_config_tready
    );

    modport slave (
        input  m_reload_tvalid, m_reload_tdata, m_reload_tlast,
        output m_reload_tready,
        input  m_config_tvalid, m_config_tdata,
        output m_config_tready
    );
endinterface
`default_nettype wire

// File: rtl/fir_skid_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_skid_fifo2                                                             |
// | Two-entry registered AXI-Stream FIFO exposing its occupancy to the writer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_skid_fifo2 #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready,
    output logic [1:0]       occupancy
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // The writer never pushes into a full FIFO: it throttles on occupancy.
    assign w_push    = s_tvalid;
    assign w_pop     = m_tvalid && m_tready;
    assign m_tvalid  = (r_count != 2'd0);
    assign m_tdata   = r_mem[r_rptr];
    assign occupancy = r_count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= s_tdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_coeff_loader                                                           |
// | Streams one coefficient set from memory to the FIR reload port, then config|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_coeff_loader
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned NUM_TAPS    = 64,
    parameter int unsigned NUM_SETS    = 16,
    parameter int unsigned SEL_WIDTH   = 4,
    parameter int unsigned CFG_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_SETS * NUM_TAPS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   load_req,
    input  logic [SEL_WIDTH-1:0]   load_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [SEL_WIDTH-1:0]   active_sel,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [COEFF_WIDTH-1:0] mem_rdata,
    fir_coeff_loader_if.master     axis
);
    localparam int unsigned         TAP_W      = $clog2(NUM_TAPS + 1);
    localparam logic [TAP_W-1:0]    C_NUM_TAPS = TAP_W'(NUM_TAPS);
    localparam logic [TAP_W-1:0]    C_LAST_TAP = TAP_W'(NUM_TAPS - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_start;
    logic [SEL_WIDTH-1:0]   w_start_sel;

    logic [SEL_WIDTH-1:0]   r_sel;
    logic [SEL_WIDTH-1:0]   r_pend_sel;
    logic                   r_pend_valid;
    logic [SEL_WIDTH-1:0]   r_active_sel;
    logic                   r_done;
    logic                   r_err;
    logic [TAP_W-1:0]       r_tap;
    logic                   r_rd_inflight;
    logic                   r_rd_last;

    logic                   w_req_ok;
    logic                   w_reload_hs;
    logic                   w_cfg_valid;
    logic                   w_cfg_hs;
    logic                   w_credit_ok;
    logic                   w_fifo_valid;
    logic [COEFF_WIDTH:0]   w_fifo_head;
    logic [1:0]             w_fifo_occ;

    assign w_req_ok    = load_req && (32'(load_sel) < NUM_SETS);
    assign w_reload_hs = w_fifo_valid && axis.m_reload_tready;
    assign w_cfg_hs    = w_cfg_valid && axis.m_config_tready;

    // Credit counts the slot freed by this cycle's pop so the FIFO can sustain
    // one beat per cycle while never holding more than two words.
    assign w_credit_ok = ({1'b0, w_fifo_occ} + {2'b00, r_rd_inflight}) <
                         (3'd2 + {2'b00, w_reload_hs});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_sel  = load_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_req_ok) begin
                    w_start      = 1'b1;
                    w_state_next = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                if (w_reload_hs && w_fifo_head[COEFF_WIDTH]) begin
                    w_state_next = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                if (w_cfg_hs) begin
                    // A request arriving on the handshake cycle is newer than the stored one.
                    if (w_req_ok) begin
                        w_start      = 1'b1;
                        w_state_next = ST_RELOAD;
                    end else if (r_pend_valid) begin
                        w_start      = 1'b1;
                        w_start_sel  = r_pend_sel;
                        w_state_next = ST_RELOAD;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != ST_IDLE);
        w_cfg_valid = (r_state == ST_CONFIG);
        mem_rd_en   = (r_state == ST_RELOAD) && (r_tap != C_NUM_TAPS) && w_credit_ok;
    end

    assign mem_addr            = ADDR_WIDTH'(coeff_addr(32'(r_sel), 32'(r_tap), NUM_TAPS));
    assign axis.m_config_tvalid = w_cfg_valid;
    assign axis.m_config_tdata  = w_cfg_valid ? CFG_WIDTH'(cfg_pad(32'(r_sel), SEL_WIDTH)) : '0;
    assign axis.m_reload_tvalid = w_fifo_valid;
    assign axis.m_reload_tdata  = w_fifo_head[COEFF_WIDTH-1:0];
    assign axis.m_reload_tlast  = w_fifo_head[COEFF_WIDTH];
    assign done                 = r_done;
    assign err                  = r_err;
    assign active_sel           = r_active_sel;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sel         <= '0;
            r_pend_sel    <= '0;
            r_pend_valid  <= 1'b0;
            r_active_sel  <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tap         <= '0;
            r_rd_inflight <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_done        <= w_cfg_hs;
            r_err         <= load_req && !w_req_ok;
            r_rd_inflight <= mem_rd_en;
            r_rd_last     <= (r_tap == C_LAST_TAP);

            if (w_cfg_hs) begin
                r_active_sel <= r_sel;
            end

            if (w_start) begin
                r_sel <= w_start_sel;
                r_tap <= '0;
            end else if (mem_rd_en) begin
                r_tap <= r_tap + 1'b1;
            end

            if (w_start) begin
                r_pend_valid <= 1'b0;
            end else if (busy && w_req_ok) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= load_sel;
            end
        end
    end

    fir_skid_fifo2 #(
        .WIDTH (COEFF_WIDTH + 1)
    ) u_reload_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tvalid  (r_rd_inflight),
        .s_tdata   ({r_rd_last, mem_rdata}),
        .m_tvalid  (w_fifo_valid),
        .m_tdata   (w_fifo_head),
        .m_tready  (axis.m_reload_tready),
        .occupancy (w_fifo_occ)
    );
endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_coeff_loader                                                        |
// | Directed bench with a beat/config scoreboard and AXIS stability checks     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_coeff_loader;
    localparam int unsigned CW = 16;
    localparam int unsigned NT = 64;
    localparam int unsigned NS = 16;
    localparam int unsigned SW = 5;
    localparam int unsigned FW = 8;
    localparam int unsigned AW = 10;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          load_req = 1'b0;
    logic [SW-1:0] load_sel = '0;
    logic          busy, done, err, mem_rd_en;
    logic [SW-1:0] active_sel;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_rdata;
    logic [CW-1:0] mem [0:(NS*NT)-1];

    fir_coeff_loader_if #(.COEFF_WIDTH(CW), .CFG_WIDTH(FW)) bus ();

    fir_coeff_loader #(
        .COEFF_WIDTH(CW), .NUM_TAPS(NT), .NUM_SETS(NS),
        .SEL_WIDTH(SW), .CFG_WIDTH(FW), .ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .load_req(load_req), .load_sel(load_sel),
        .busy(busy), .done(done), .err(err), .active_sel(active_sel),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .axis(bus)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    typedef struct packed { logic [CW-1:0] d; logic l; } beat_t;
    beat_t         exp_beats[$];
    logic [FW-1:0] exp_cfg[$];
    logic [SW-1:0] exp_active = '0;

    int checks = 0, failures = 0;
    int cyc = 0, req_cyc = 0;
    int beat_cnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, busy_cnt = 0;
    int first_beat_cyc = -1, last_tlast_cyc = -1, last_done_cyc = -1;
    logic busy_at_done = 1'b0;
    logic rnd_ready = 1'b0;
    logic p_rv = 1'b0, p_rl = 1'b0, p_cv = 1'b0, p_cfg_hs = 1'b0, p_err_exp = 1'b0;
    logic [CW-1:0] p_rd = '0;
    logic [FW-1:0] p_cd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic  rhs, chs;
        beat_t b;
        logic [FW-1:0] c;
        rhs = bus.m_reload_tvalid && bus.m_reload_tready;
        chs = bus.m_config_tvalid && bus.m_config_tready;
        if (p_rv) begin
            chk("reload_hold_valid", 32'(bus.m_reload_tvalid), 32'd1);
            chk("reload_hold_data", 32'(bus.m_reload_tdata), 32'(p_rd));
            chk("reload_hold_last", 32'(bus.m_reload_tlast), 32'(p_rl));
        end
        if (p_cv) begin
            chk("config_hold_valid", 32'(bus.m_config_tvalid), 32'd1);
            chk("config_hold_data", 32'(bus.m_config_tdata), 32'(p_cd));
        end
        chk("done_after_cfg_hs", 32'(done), 32'(p_cfg_hs));
        chk("err_after_bad_req", 32'(err), 32'(p_err_exp));
        if (rhs) begin
            if (exp_beats.size() == 0) begin
                chk("reload_unexpected_beat", 32'(exp_beats.size()), 32'd1);
            end else begin
                b = exp_beats.pop_front();
                chk("reload_data", 32'(bus.m_reload_tdata), 32'(b.d));
                chk("reload_last", 32'(bus.m_reload_tlast), 32'(b.l));
            end
            beat_cnt++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            if (bus.m_reload_tlast) last_tlast_cyc = cyc;
        end
        if (chs) begin
            if (exp_cfg.size() == 0) begin
                chk("config_unexpected_beat", 32'(exp_cfg.size()), 32'd1);
            end else begin
                c = exp_cfg.pop_front();
                chk("config_data", 32'(bus.m_config_tdata), 32'(c));
                exp_active = c[SW-1:0];
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            busy_at_done  = busy;
            chk("active_sel_on_done", 32'(active_sel), 32'(exp_active));
        end
        if (err) err_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (busy) busy_cnt++;
        p_rv      = bus.m_reload_tvalid && !bus.m_reload_tready;
        p_rd      = bus.m_reload_tdata;
        p_rl      = bus.m_reload_tlast;
        p_cv      = bus.m_config_tvalid && !bus.m_config_tready;
        p_cd      = bus.m_config_tdata;
        p_cfg_hs  = chs;
        p_err_exp = load_req && (32'(load_sel) >= NS);
    endtask

    task automatic cycle();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        cyc++;
        if (rnd_ready) begin
            bus.m_reload_tready = 1'($urandom_range(0, 1));
            bus.m_config_tready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic request(input int sel);
        load_sel = SW'(sel);
        load_req = 1'b1;
        req_cyc  = cyc;
        cycle();
        load_req = 1'b0;
    endtask

    task automatic expect_set(input int sel);
        beat_t b;
        for (int t = 0; t < NT; t++) begin
            b.d = CW'((sel << 8) | t);
            b.l = (t == NT - 1);
            exp_beats.push_back(b);
        end
        exp_cfg.push_back(FW'(sel));
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int start, k;
        start = done_cnt;
        k = 0;
        while (done_cnt < start + n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 32'(done_cnt - start), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0, r0, b0, d0, k;
        for (int s = 0; s < NS; s++)
            for (int t = 0; t < NT; t++)
                mem[s*NT + t] = CW'((s << 8) | t);
        bus.m_reload_tready = 1'b1;
        bus.m_config_tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_active_sel", 32'(active_sel), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_reload_tvalid", 32'(bus.m_reload_tvalid), 32'd0);
        chk("rst_config_tvalid", 32'(bus.m_config_tvalid), 32'd0);
        aresetn = 1'b1;
        cycle();
        cycle();

        // Set 3 with continuous tready: exact cycle timing.
        expect_set(3);
        first_beat_cyc = -1;
        request(3);
        c0 = req_cyc;
        wait_done(1, 200, "A_done");
        chk("A_first_beat_cycle", 32'(first_beat_cyc - c0), 32'd3);
        chk("A_tlast_cycle", 32'(last_tlast_cyc - c0), 32'(NT + 2));
        chk("A_done_cycle", 32'(last_done_cyc - c0), 32'(NT + 4));
        chk("A_active_sel", 32'(active_sel), 32'd3);
        chk("A_busy_low", 32'(busy), 32'd0);
        chk("A_queue_empty", 32'(exp_beats.size() + exp_cfg.size()), 32'd0);

        // Same set with random back-pressure on both channels.
        rnd_ready = 1'b1;
        expect_set(3);
        request(3);
        wait_done(1, 2000, "B_done");
        rnd_ready = 1'b0;
        bus.m_reload_tready = 1'b1;
        bus.m_config_tready = 1'b1;
        chk("B_queue_empty", 32'(exp_beats.size() + exp_cfg.size()), 32'd0);
        cycle();

        // Pending requests: 5 is overwritten by 7.
        expect_set(2);
        expect_set(7);
        r0 = rd_cnt;
        request(2);
        repeat (10) cycle();
        request(5);
        repeat (5) cycle();
        request(7);
        wait_done(1, 200, "C_first_done");
        chk("C_busy_held_at_done", 32'(busy_at_done), 32'd1);
        wait_done(1, 200, "C_second_done");
        chk("C_active_sel", 32'(active_sel), 32'd7);
        chk("C_read_count", 32'(rd_cnt - r0), 32'(2 * NT));
        chk("C_queue_empty", 32'(exp_beats.size() + exp_cfg.size()), 32'd0);
        cycle();

        // Out-of-range request in IDLE.
        e0 = err_cnt; r0 = rd_cnt; b0 = busy_cnt;
        request(NS);
        repeat (4) cycle();
        chk("D_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("D_no_reads", 32'(rd_cnt - r0), 32'd0);
        chk("D_busy_stays_low", 32'(busy_cnt - b0), 32'd0);

        // Reset in the middle of a reload, then restart from tap 0.
        expect_set(3);
        b0 = beat_cnt;
        request(3);
        k = 0;
        while (beat_cnt - b0 < 20 && k < 200) begin
            cycle();
            k++;
        end
        chk("E_reached_beat20", 32'(beat_cnt - b0), 32'd20);
        aresetn = 1'b0;
        #1;
        chk("E_rst_busy", 32'(busy), 32'd0);
        chk("E_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("E_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("E_rst_reload_tvalid", 32'(bus.m_reload_tvalid), 32'd0);
        chk("E_rst_reload_tdata", 32'(bus.m_reload_tdata), 32'd0);
        chk("E_rst_config_tvalid", 32'(bus.m_config_tvalid), 32'd0);
        chk("E_rst_active_sel", 32'(active_sel), 32'd0);
        exp_beats.delete();
        exp_cfg.delete();
        exp_active = '0;
        p_rv = 1'b0; p_cv = 1'b0; p_cfg_hs = 1'b0; p_err_exp = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cycle();
        expect_set(4);
        request(4);
        wait_done(1, 200, "E_done_after_reset");
        chk("E_active_sel", 32'(active_sel), 32'd4);
        chk("E_queue_empty", 32'(exp_beats.size() + exp_cfg.size()), 32'd0);

        // Config back-pressure for 10 cycles.
        bus.m_config_tready = 1'b0;
        expect_set(1);
        request(1);
        k = 0;
        while (!bus.m_config_tvalid && k < 200) begin
            cycle();
            k++;
        end
        chk("F_cfg_valid_seen", 32'(bus.m_config_tvalid), 32'd1);
        d0 = done_cnt;
        repeat (10) cycle();
        chk("F_busy_during_stall", 32'(busy), 32'd1);
        chk("F_no_done_during_stall", 32'(done_cnt - d0), 32'd0);
        chk("F_cfg_data_held", 32'(bus.m_config_tdata), 32'd1);
        bus.m_config_tready = 1'b1;
        wait_done(1, 20, "F_done_after_hs");
        chk("F_active_sel", 32'(active_sel), 32'd1);
        chk("F_queue_empty", 32'(exp_beats.size() + exp_cfg.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
